// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_reg_skid pipeline-stage register:
// occupancy state encoding and the default payload width.
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // FULL is 11 so that bit 0 alone means "main register valid".
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

endpackage

// File: rtl/pipe_dff.sv
// WIDTH-bit data register with synchronous active-high clear to RESET_VAL
// and a load enable; used for both the main and the skid slot.
module pipe_dff
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer
// and synchronous flush. Define PIPE_REG_STATS_EN to add the stall_cnt port.
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    state_t           state;
    state_t           state_next;
    logic             acc;
    logic             con;
    logic             main_en;
    logic             skid_en;
    logic             clear;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    // Handshake outputs depend on registered state only, never on out_ready.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign acc       = in_valid && in_ready;
    assign con       = out_valid && out_ready;
    assign clear     = rst || flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        main_en    = 1'b0;
        skid_en    = 1'b0;
        main_d     = in_data;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_next = BUSY;
                    main_en    = 1'b1;
                end
            end
            BUSY: begin
                if (acc && con) begin
                    main_en = 1'b1;
                end else if (acc) begin
                    state_next = FULL;
                    skid_en    = 1'b1;
                end else if (con) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (con) begin
                    state_next = BUSY;
                    main_en    = 1'b1;
                    main_d     = skid_q;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush discards both slots and any same-cycle input transfer.
        if (flush) begin
            state_next = EMPTY;
        end
    end

    pipe_dff #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk (clk),
        .rst (clear),
        .en  (main_en),
        .d   (main_d),
        .q   (out_data)
    );

    pipe_dff #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk (clk),
        .rst (clear),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

`ifdef PIPE_REG_STATS_EN
    // Saturating stall counter; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Self-checking bench for pipe_reg_skid: queue-based occupancy model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_pipe_reg_skid;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef PIPE_REG_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    bit chk_en       = 1'b0;

    // Model: the stage is a FIFO of depth 2; shown is what out_data displays.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_shown;
    int               m_cnt;

    always #5 clk = ~clk;

    pipe_reg_skid #(.WIDTH(WIDTH), .RESET_VAL(32'h0), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_REG_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each edge from the inputs seen at that edge.
    always @(posedge clk) begin
        bit m_acc;
        bit m_con;
        bit stalled;
        stalled = (mq.size() > 0) && !out_ready;
        if (rst || flush) begin
            mq.delete();
            m_shown = '0;
        end else begin
            m_acc = in_valid && (mq.size() < 2);
            m_con = (mq.size() > 0) && out_ready;
            if (m_con) void'(mq.pop_front());
            if (m_acc) mq.push_back(in_data);
            if (mq.size() > 0) m_shown = mq[0];
        end
        if (rst) m_cnt = 0;
        else if (stalled && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("model out_valid", 32'(out_valid), 32'(mq.size() > 0));
            check_output("model in_ready", 32'(in_ready), 32'(mq.size() < 2));
            check_output("model out_data", out_data, m_shown);
`ifdef PIPE_REG_STATS_EN
            check_output("model stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
        end
    end

    task automatic apply_stimulus(input logic iv, input logic [31:0] d, input logic ordy,
                                  input logic fl, input logic r);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset while upstream offers data.
        apply_stimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        check_output("reset out_valid", 32'(out_valid), 32'd0);
        check_output("reset in_ready", 32'(in_ready), 32'd1);
        check_output("reset out_data", out_data, 32'd0);

        // Streaming 1..4 at full throughput.
        for (int k = 1; k <= 4; k++) begin
            apply_stimulus(1'b1, 32'(k), 1'b1, 1'b0, 1'b0);
            check_output("stream out_data", out_data, 32'(k));
            check_output("stream in_ready", 32'(in_ready), 32'd1);
        end
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_output("stream drained", 32'(out_valid), 32'd0);

        // Back-pressure: 5 in main, 6 into skid, 7 held upstream.
        apply_stimulus(1'b1, 32'd5, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'd6, 1'b0, 1'b0, 1'b0);
        check_output("bp in_ready full", 32'(in_ready), 32'd0);
        check_output("bp hold 5", out_data, 32'd5);
        apply_stimulus(1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
        check_output("bp still 5", out_data, 32'd5);
        apply_stimulus(1'b1, 32'd7, 1'b1, 1'b0, 1'b0);
        check_output("bp out 6", out_data, 32'd6);
        apply_stimulus(1'b1, 32'd7, 1'b1, 1'b0, 1'b0);
        check_output("bp out 7", out_data, 32'd7);
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_output("bp drained", 32'(out_valid), 32'd0);

        // Flush while FULL with a same-cycle input of 9.
        apply_stimulus(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'd6, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'd9, 1'b0, 1'b1, 1'b0);
        check_output("flush out_valid", 32'(out_valid), 32'd0);
        check_output("flush in_ready", 32'(in_ready), 32'd1);
        check_output("flush out_data", out_data, 32'd0);
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_output("flush no 9", 32'(out_valid), 32'd0);

        // Reset while FULL and downstream ready: 6 must never emerge.
        apply_stimulus(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'd6, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        check_output("rst mid out_valid", 32'(out_valid), 32'd0);
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_output("rst mid no 6", 32'(out_valid), 32'd0);

`ifdef PIPE_REG_STATS_EN
        // Saturation at 15 with CNT_W=4; flush keeps it, reset clears it.
        check_output("stats after rst", 32'(stall_cnt), 32'd0);
        apply_stimulus(1'b1, 32'd8, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        check_output("stats count 3", 32'(stall_cnt), 32'd3);
        for (int k = 0; k < 17; k++) apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        check_output("stats saturate", 32'(stall_cnt), 32'd15);
        check_output("stats hold data", out_data, 32'd8);
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        check_output("stats after flush", 32'(stall_cnt), 32'd15);
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check_output("stats cleared", 32'(stall_cnt), 32'd0);
`endif

        // Mixed pattern of valid/ready gaps, checked by the model each cycle.
        for (int i = 0; i < 48; i++) begin
            apply_stimulus(1'(i % 3 != 0), 32'(100 + i), 1'(i % 4 != 1), 1'(i == 30), 1'b0);
        end
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_output("final empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
